// File: rtl/unit_sched_pkg.sv
// Shared definitions for the window scheduler: FSM encoding and the default
// image geometry / pooled-result latency.
package unit_sched_pkg;

  localparam int DEF_IMG_W    = 28;
  localparam int DEF_IMG_H    = 28;
  localparam int DEF_PIPE_LAT = 3;

  // 2-bit scheduler state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sched_delay_line.sv
// 1-bit tag delay line. A tag entering on i_tag appears on o_tag DEPTH cycles
// later. The line shifts every cycle, so input stalls never hold a tag back.
// o_in_flight is set while any tag has not yet reached the output stage, i.e.
// the line will still produce an o_tag pulse after the current cycle.
module sched_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tag,
  output logic o_tag,
  output logic o_in_flight
);

  logic [DEPTH-1:0] r_sr;
  logic [DEPTH-1:0] w_sr_next;
  logic             w_in_flight;

  // Next shift-register value: everything moves one stage toward the output.
  always_comb begin
    w_sr_next    = r_sr << 1;
    w_sr_next[0] = i_tag;
  end

  // Tags still short of the output stage (the output stage leaves this cycle).
  always_comb begin
    w_in_flight = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_in_flight = w_in_flight | r_sr[i];
    end
  end

  // Shift register, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

  assign o_tag       = r_sr[DEPTH-1];
  assign o_in_flight = w_in_flight;

endmodule

// File: rtl/unit_sched.sv
// Control scheduler for a 3x3 conv + 2x2 pool unit. Walks the conv windows of
// one image in raster order, marks row starts and pooling phase, and emits a
// pooled-pixel valid PIPE_LAT cycles after each window that completes a 2x2
// pool block. Drives control pins only; no pixel data passes through here.
//
// Handshake: in_valid means a column word is present this cycle. In RUN the
// window advances exactly on cycles with in_valid=1 (enable = in_valid); a
// cycle with in_valid=0 is a stall that holds rd_row/rd_col and suppresses
// num_block_change. There is no back-pressure: out_valid is a one-cycle strobe
// and is never held by stalls.
module unit_sched
  import unit_sched_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     busy,
  output logic [$clog2(IMG_H)-1:0] rd_row,
  output logic [$clog2(IMG_W)-1:0] rd_col,
  output logic                     enable,
  output logic                     num_block_change,
  output logic                     i_2,
  output logic                     out_valid,
  output logic                     done
);

  localparam int OW = IMG_W - 2;
  localparam int OH = IMG_H - 2;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  sched_state_t  r_state;
  logic          r_busy;
  logic          r_done;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  logic w_en;
  logic w_col_last;
  logic w_row_last;
  logic w_last_win;
  logic w_tag;
  logic w_out_tag;
  logic w_in_flight;

  assign w_en       = (r_state == ST_RUN) & in_valid;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_last_win = w_en & w_col_last & w_row_last;
  // Odd row and odd column closes a 2x2 pool block.
  assign w_tag      = w_en & r_row[0] & r_col[0];

  // Raster window counters; wrap to (0,0) after the last window of the image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_en) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Scheduler FSM with registered busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last_win) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave once the final tag has reached the output stage.
          if (!w_in_flight) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  sched_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_tag      (w_tag),
    .o_tag      (w_out_tag),
    .o_in_flight(w_in_flight)
  );

  assign busy             = r_busy;
  assign done             = r_done;
  assign rd_row           = r_row;
  assign rd_col           = r_col;
  assign enable           = w_en;
  assign num_block_change = w_en & (r_col == '0);
  assign i_2              = r_row[0];
  assign out_valid        = w_out_tag;

endmodule

// File: tb/tb_unit_sched.sv
// Directed bench for unit_sched: 6x6 images under several in_valid patterns,
// restart/done-cycle start attempts, mid-image reset, and a default 28x28 run.
module tb_unit_sched;

  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 6x6 DUT ----------------
  logic       start6 = 1'b0;
  logic       in_valid6 = 1'b0;
  logic       busy6, en6, nbc6, i2_6, ov6, done6;
  logic [2:0] row6, col6;

  unit_sched #(.IMG_W(6), .IMG_H(6), .PIPE_LAT(LAT)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .in_valid(in_valid6),
    .busy(busy6), .rd_row(row6), .rd_col(col6), .enable(en6),
    .num_block_change(nbc6), .i_2(i2_6), .out_valid(ov6), .done(done6)
  );

  // ---------------- 28x28 DUT (defaults) ----------------
  logic       start28 = 1'b0;
  logic       in_valid28 = 1'b0;
  logic       busy28, en28, nbc28, i2_28, ov28, done28;
  logic [4:0] row28, col28;

  unit_sched u_dut28 (
    .clk(clk), .rst(rst), .start(start28), .in_valid(in_valid28),
    .busy(busy28), .rd_row(row28), .rd_col(col28), .enable(en28),
    .num_block_change(nbc28), .i_2(i2_28), .out_valid(ov28), .done(done28)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at #1 after the edge that moves the DUT into RUN (cycle 0).
  task automatic start_img6();
    @(posedge clk); #1 start6 = 1'b1;
    @(posedge clk); #1 start6 = 1'b0;
  endtask

  // One 6x6 image. mode: 0 in_valid=1, 1 toggling 1,0, 2 low on cyc%3==1.
  task automatic run6(input string tag, input int mode, input int exp_last,
                      input bit restart, input bit start_done);
    int cyc = 0;
    int n_en = 0, n_en_dut = 0, n_nbc = 0, n_ov = 0, n_done = 0;
    int done_cyc = -1, last_en = -1;
    int bad_ras = 0, bad_ov = 0, bad_busy = 0;
    int r = 0, c = 0;
    bit v, exp_en, exp_busy;
    exp_q.delete();
    start_img6();
    while (cyc < 200 && !(last_en >= 0 && cyc > last_en + LAT + 4)) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = (cyc % 3 != 1);
      endcase
      in_valid6 = v;
      start6 = (restart && cyc == 5) ||
               (start_done && last_en >= 0 && cyc == last_en + LAT + 1);
      @(negedge clk);
      exp_en = (n_en < 16) && v;
      if (en6 !== exp_en) bad_ras++;
      if (en6) n_en_dut++;
      if (exp_en) begin
        if (row6 !== 3'(r) || col6 !== 3'(c) || nbc6 !== (c == 0) || i2_6 !== r[0]) bad_ras++;
        if (r % 2 == 1 && c % 2 == 1) exp_q.push_back(32'(cyc + LAT));
        n_en++;
        if (n_en == 16) last_en = cyc;
        if (c == 3) begin c = 0; r++; end else c++;
      end else begin
        if (nbc6 !== 1'b0) bad_ras++;
        if (n_en < 16 && (row6 !== 3'(r) || col6 !== 3'(c))) bad_ras++;
      end
      if (nbc6) n_nbc++;
      if (ov6) begin
        n_ov++;
        if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) void'(exp_q.pop_front());
        else bad_ov++;
      end
      if (done6) begin n_done++; done_cyc = cyc; end
      exp_busy = !(last_en >= 0 && cyc > last_en + LAT + 1);
      if (busy6 !== exp_busy) bad_busy++;
      @(posedge clk); #1;
      cyc++;
    end
    start6 = 1'b0;
    in_valid6 = 1'b0;
    check({tag, "_enables"},     n_en_dut, 16);
    check({tag, "_blk_change"},  n_nbc, 4);
    check({tag, "_out_valid"},   n_ov, 4);
    check({tag, "_done_count"},  n_done, 1);
    check({tag, "_last_enable"}, last_en, exp_last);
    check({tag, "_done_delay"},  done_cyc - last_en, LAT + 1);
    check({tag, "_raster_errs"}, bad_ras, 0);
    check({tag, "_ov_timing"},   bad_ov, 0);
    check({tag, "_ov_missing"},  exp_q.size(), 0);
    check({tag, "_busy_errs"},   bad_busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n_en, n_nbc, n_ov, n_done, done_c, stale;

    // Reset state: outputs low even with in_valid high.
    in_valid6 = 1'b1;
    in_valid28 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs6", {busy6, en6, nbc6, i2_6, ov6, done6, row6, col6}, 0);
    check("reset_outs28", {busy28, en28, nbc28, i2_28, ov28, done28, row28, col28}, 0);
    in_valid6 = 1'b0;
    in_valid28 = 1'b0;
    rst = 1'b1;

    run6("base",     0, 15, 1'b0, 1'b0);
    run6("toggle",   1, 30, 1'b0, 1'b0);
    run6("pattern3", 2, 23, 1'b0, 1'b0);
    run6("restart",  0, 15, 1'b1, 1'b0);
    run6("done_start", 0, 15, 1'b0, 1'b1);
    run6("after_done", 0, 15, 1'b0, 1'b0);

    // Mid-image reset at window (2,1).
    in_valid6 = 1'b1;
    start_img6();
    repeat (9) begin @(posedge clk); #1; end
    check("rst_win_row", row6, 2);
    check("rst_win_col", col6, 1);
    rst = 1'b0;
    #1;
    check("rst_outs_now", {busy6, en6, nbc6, i2_6, ov6, done6, row6, col6}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs_held", {busy6, en6, nbc6, i2_6, ov6, done6, row6, col6}, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid6 = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov6 || done6 || busy6) stale++;
    end
    check("post_rst_idle", stale, 0);
    run6("after_rst", 0, 15, 1'b0, 1'b0);

    // Default 28x28 image.
    cyc = 0; n_en = 0; n_nbc = 0; n_ov = 0; n_done = 0; done_c = 0;
    @(posedge clk); #1 start28 = 1'b1; in_valid28 = 1'b1;
    @(posedge clk); #1 start28 = 1'b0;
    while (cyc < 2000 && !(n_done > 0 && cyc > done_c + 3)) begin
      @(negedge clk);
      if (en28) n_en++;
      if (nbc28) n_nbc++;
      if (ov28) n_ov++;
      if (done28) begin n_done++; done_c = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid28 = 1'b0;
    check("img28_enables",    n_en, 676);
    check("img28_blk_change", n_nbc, 26);
    check("img28_out_valid",  n_ov, 169);
    check("img28_done_count", n_done, 1);
    check("img28_busy_end",   busy28, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
